// File: rtl/exec_pkg.sv
// ---------------------------------------------------------------------------
// exec_pkg
// Shared constants for the execute/memory slice of the 16-bit processor.
// Contents:
//   DATA_W       datapath width
//   OP_*         instruction[15:12] opcode values
//   ALU_*        3-bit ALU operation codes
//   WD_*         write-back source select encodings (wrtdata)
// ---------------------------------------------------------------------------
package exec_pkg;

  localparam int DATA_W = 16;

  // Opcodes carried in instruction[15:12]
  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_NOR   = 4'h5;
  localparam logic [3:0] OP_SLT   = 4'h6;
  localparam logic [3:0] OP_SHIFT = 4'h7;
  localparam logic [3:0] OP_LW    = 4'h8;
  localparam logic [3:0] OP_SW    = 4'h9;
  localparam logic [3:0] OP_BEQ   = 4'hA;
  localparam logic [3:0] OP_JUMP  = 4'hB;
  localparam logic [3:0] OP_PUSH  = 4'hC;
  localparam logic [3:0] OP_POP   = 4'hD;
  localparam logic [3:0] OP_NOP   = 4'hE;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_XOR   = 3'b100;
  localparam logic [2:0] ALU_NOR   = 3'b101;
  localparam logic [2:0] ALU_SLT   = 3'b110;
  localparam logic [2:0] ALU_PASSB = 3'b111;

  // Write-back source select
  localparam logic [1:0] WD_ALUMEM = 2'b00;
  localparam logic [1:0] WD_SHIFT  = 2'b01;
  localparam logic [1:0] WD_STACK  = 2'b10;

endpackage

// File: rtl/exec_alu.sv
// ---------------------------------------------------------------------------
// exec_alu
// Combinational ALU with zero/overflow/carry/sign flags.
// Ports:
//   i_a, i_b     operands (A = r1, B = r2)
//   i_carryin    carry into the ADD operation
//   i_aluop      operation select (ALU_* in exec_pkg)
//   o_result     result word
//   o_zero       result == 0
//   o_overflow   signed overflow (ADD/SUB only)
//   o_carryout   bit 16 of the 17-bit sum (ADD/SUB only)
//   o_sign       result MSB
// ---------------------------------------------------------------------------
module exec_alu
  import exec_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_carryin,
  input  logic [2:0]   i_aluop,
  output logic [W-1:0] o_result,
  output logic         o_zero,
  output logic         o_overflow,
  output logic         o_carryout,
  output logic         o_sign
);

  logic [W:0] w_sum;
  logic [W:0] w_diff;

  // Both adders are always computed; the op select only picks which one
  // drives the result. Subtraction is A + ~B + 1 so carry-out means "no borrow".
  always_comb begin
    w_sum      = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_carryin};
    w_diff     = {1'b0, i_a} + {1'b0, ~i_b} + {{W{1'b0}}, 1'b1};
    o_result   = '0;
    o_carryout = 1'b0;
    o_overflow = 1'b0;
    case (i_aluop)
      ALU_ADD: begin
        o_result   = w_sum[W-1:0];
        o_carryout = w_sum[W];
        o_overflow = (i_a[W-1] == i_b[W-1]) && (w_sum[W-1] != i_a[W-1]);
      end
      ALU_SUB: begin
        o_result   = w_diff[W-1:0];
        o_carryout = w_diff[W];
        o_overflow = (i_a[W-1] != i_b[W-1]) && (w_diff[W-1] != i_a[W-1]);
      end
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_XOR: o_result = i_a ^ i_b;
      ALU_NOR: o_result = ~(i_a | i_b);
      ALU_SLT: o_result = ($signed(i_a) < $signed(i_b)) ? {{(W-1){1'b0}}, 1'b1} : '0;
      default: o_result = i_b;
    endcase
  end

  assign o_zero = (o_result == '0);
  assign o_sign = o_result[W-1];

endmodule

// File: rtl/exec_mem_unit.sv
// ---------------------------------------------------------------------------
// exec_mem_unit
// Execute/memory slice: opcode decoder, ALU (exec_alu) and 256x16 data
// memory with address-select and memory-to-register muxes.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//                         (reset clears every data-memory word)
//   instruction           current instruction; [15:12] is the opcode
//   r1, r2, carryin       ALU operands / push source / store data, carry in
//   lwsw .. pop, wrtdata, aluop   decoded control outputs
//   alu_result + flags    ALU result, zero/overflow/carryout/sign
//   mem_rdata             data-memory read data
//   wb_data               memtoreg ? mem_rdata : alu_result
// Build option:
//   DMEM_READ_GATE_EN     when defined, mem_rdata reads 0 unless memread=1;
//                         otherwise mem_rdata is the addressed word always.
// ---------------------------------------------------------------------------
module exec_mem_unit
  import exec_pkg::*;
#(
  parameter int DMEM_DEPTH = 256,
  parameter int DATA_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       instruction,
  input  logic [DATA_W-1:0] r1,
  input  logic [DATA_W-1:0] r2,
  input  logic              carryin,
  output logic              lwsw,
  output logic              jump,
  output logic              branch,
  output logic              memread,
  output logic              memwrt,
  output logic              memtoreg,
  output logic              regwrt,
  output logic              regsrc,
  output logic              push,
  output logic              pop,
  output logic [1:0]        wrtdata,
  output logic [2:0]        aluop,
  output logic [DATA_W-1:0] alu_result,
  output logic              zero,
  output logic              overflow,
  output logic              carryout,
  output logic              sign,
  output logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] wb_data
);

  logic [3:0]        w_opcode;
  logic [7:0]        w_addr;
  logic [DATA_W-1:0] r_mem [DMEM_DEPTH];

  assign w_opcode = instruction[15:12];

  // Control decoder: every control defaults low, each opcode raises only
  // the signals it needs. ALU ops reuse the low opcode bits as aluop.
  always_comb begin
    lwsw     = 1'b0;
    jump     = 1'b0;
    branch   = 1'b0;
    memread  = 1'b0;
    memwrt   = 1'b0;
    memtoreg = 1'b0;
    regwrt   = 1'b0;
    regsrc   = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    wrtdata  = WD_ALUMEM;
    aluop    = ALU_ADD;
    case (w_opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT: begin
        aluop  = w_opcode[2:0];
        regwrt = 1'b1;
      end
      OP_SHIFT: begin
        wrtdata = WD_SHIFT;
        regsrc  = 1'b1;
        regwrt  = 1'b1;
      end
      OP_LW: begin
        lwsw     = 1'b1;
        memread  = 1'b1;
        memtoreg = 1'b1;
        regwrt   = 1'b1;
      end
      OP_SW:   memwrt = 1'b1;
      OP_BEQ: begin
        branch = 1'b1;
        aluop  = ALU_SUB;
      end
      OP_JUMP: jump = 1'b1;
      OP_PUSH: begin
        push   = 1'b1;
        regsrc = 1'b1;
      end
      OP_POP: begin
        pop     = 1'b1;
        wrtdata = WD_STACK;
        regwrt  = 1'b1;
      end
      default: ;
    endcase
  end

  exec_alu #(.W(DATA_W)) u_alu (
    .i_a        (r1),
    .i_b        (r2),
    .i_carryin  (carryin),
    .i_aluop    (aluop),
    .o_result   (alu_result),
    .o_zero     (zero),
    .o_overflow (overflow),
    .o_carryout (carryout),
    .o_sign     (sign)
  );

  // LW carries its address in the low byte; SW carries it in [11:4]
  // because the low nibble there names the source register.
  assign w_addr = lwsw ? instruction[7:0] : instruction[11:4];

  // Reset wipes the whole array in one edge and beats a same-cycle store.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DMEM_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (memwrt) begin
      r_mem[w_addr] <= r2;
    end
  end

`ifdef DMEM_READ_GATE_EN
  assign mem_rdata = memread ? r_mem[w_addr] : '0;
`else
  assign mem_rdata = r_mem[w_addr];
`endif

  assign wb_data = memtoreg ? mem_rdata : alu_result;

endmodule

// File: tb/tb_exec_mem_unit.sv
// ---------------------------------------------------------------------------
// tb_exec_mem_unit
// Scoreboard bench for exec_mem_unit: directed cases followed by random
// instructions, expected outputs from a behavioural model of the slice.
// ---------------------------------------------------------------------------
module tb_exec_mem_unit;

  typedef struct {
    logic [9:0]  ctrl;
    logic [1:0]  wd;
    logic [2:0]  aop;
    logic [15:0] res;
    logic [3:0]  flags;
    logic        memKnown;
    logic [15:0] rdata;
    logic [15:0] wb;
    int          cyc;
  } expect_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instruction;
  logic [15:0] r1;
  logic [15:0] r2;
  logic        carryin;
  logic        lwsw, jump, branch, memread, memwrt, memtoreg, regwrt, regsrc, push, pop;
  logic [1:0]  wrtdata;
  logic [2:0]  aluop;
  logic [15:0] aluResult;
  logic        zero, overflow, carryout, sign;
  logic [15:0] memRdata;
  logic [15:0] wbData;

  expect_t     sbq[$];
  logic [15:0] modelMem [256];
  bit          memInit = 0;
  int          cycleNum = 0;
  int          assertCount = 0;
  int          failCount = 0;

  exec_mem_unit dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .r1          (r1),
    .r2          (r2),
    .carryin     (carryin),
    .lwsw        (lwsw),
    .jump        (jump),
    .branch      (branch),
    .memread     (memread),
    .memwrt      (memwrt),
    .memtoreg    (memtoreg),
    .regwrt      (regwrt),
    .regsrc      (regsrc),
    .push        (push),
    .pop         (pop),
    .wrtdata     (wrtdata),
    .aluop       (aluop),
    .alu_result  (aluResult),
    .zero        (zero),
    .overflow    (overflow),
    .carryout    (carryout),
    .sign        (sign),
    .mem_rdata   (memRdata),
    .wb_data     (wbData)
  );

  always #5 clk = ~clk;

  // Single comparison point; every check goes through here.
  task automatic cmp(input string name, input int cyc, input logic [15:0] act, input logic [15:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: control table plus arithmetic on integers, then the
  // expected response is queued and the model memory takes the store.
  task automatic applyStimulus(input logic [15:0] ins, input logic [15:0] a, input logic [15:0] b,
                               input logic cin, input logic rst);
    expect_t     e;
    logic [3:0]  op;
    logic [9:0]  c;
    logic [7:0]  addr;
    int          ua, ub, sa, sb, full, sfull;
    logic [15:0] res;
    logic        cy, ov;
    @(posedge clk);
    #1;
    reset       = rst;
    instruction = ins;
    r1          = a;
    r2          = b;
    carryin     = cin;
    cycleNum++;
    op = ins[15:12];
    // {lwsw,jump,branch,memread,memwrt,memtoreg,regwrt,regsrc,push,pop}
    c = 10'b0;
    e.wd = 2'b00;
    e.aop = 3'b000;
    if (op <= 4'h6) begin
      e.aop = op[2:0];
      c = 10'b0000001000;
    end else if (op == 4'h7) begin
      c = 10'b0000001100;
      e.wd = 2'b01;
    end else if (op == 4'h8) c = 10'b1001011000;
    else if (op == 4'h9) c = 10'b0000100000;
    else if (op == 4'hA) begin
      c = 10'b0010000000;
      e.aop = 3'b001;
    end else if (op == 4'hB) c = 10'b0100000000;
    else if (op == 4'hC) c = 10'b0000000110;
    else if (op == 4'hD) begin
      c = 10'b0000001001;
      e.wd = 2'b10;
    end
    e.ctrl = c;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    cy = 1'b0;
    ov = 1'b0;
    case (e.aop)
      3'd0: begin
        full  = ua + ub + int'(cin);
        res   = 16'(full % 65536);
        cy    = (full > 65535);
        sfull = sa + sb + int'(cin);
        ov    = (sfull > 32767) || (sfull < -32768);
      end
      3'd1: begin
        res   = 16'((ua - ub + 65536) % 65536);
        cy    = (ua >= ub);
        sfull = sa - sb;
        ov    = (sfull > 32767) || (sfull < -32768);
      end
      3'd2: res = a & b;
      3'd3: res = a | b;
      3'd4: res = a ^ b;
      3'd5: res = ~(a | b);
      3'd6: res = (sa < sb) ? 16'd1 : 16'd0;
      default: res = b;
    endcase
    e.res   = res;
    e.flags = {res == 16'd0, ov, cy, res[15]};
    addr    = (op == 4'h8) ? ins[7:0] : ins[11:4];
    e.memKnown = memInit;
`ifdef DMEM_READ_GATE_EN
    e.rdata = (op == 4'h8) ? modelMem[addr] : 16'h0000;
`else
    e.rdata = modelMem[addr];
`endif
    e.wb  = (op == 4'h8) ? e.rdata : res;
    e.cyc = cycleNum;
    sbq.push_back(e);
    if (rst) begin
      for (int i = 0; i < 256; i++) modelMem[i] = 16'h0000;
      memInit = 1;
    end else if (op == 4'h9) begin
      modelMem[addr] = b;
    end
  endtask

  task automatic checkOutput(input expect_t e);
    cmp("ctrl", e.cyc, {6'b0, lwsw, jump, branch, memread, memwrt, memtoreg, regwrt, regsrc, push, pop},
        {6'b0, e.ctrl});
    cmp("wrtdata", e.cyc, {14'b0, wrtdata}, {14'b0, e.wd});
    cmp("aluop", e.cyc, {13'b0, aluop}, {13'b0, e.aop});
    cmp("alu_result", e.cyc, aluResult, e.res);
    cmp("flags_zocs", e.cyc, {12'b0, zero, overflow, carryout, sign}, {12'b0, e.flags});
    if (e.memKnown) begin
      cmp("mem_rdata", e.cyc, memRdata, e.rdata);
      cmp("wb_data", e.cyc, wbData, e.wb);
    end else if (e.ctrl[4] == 1'b0) begin
      cmp("wb_data", e.cyc, wbData, e.wb);
    end
  endtask

  // Monitor: outputs are combinational, so one response per cycle,
  // sampled at the falling edge.
  initial begin
    expect_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [15:0] pickOperand();
    logic [15:0] edges [5];
    edges[0] = 16'h0000;
    edges[1] = 16'h0001;
    edges[2] = 16'h7FFF;
    edges[3] = 16'h8000;
    edges[4] = 16'hFFFF;
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
    return 16'($urandom);
  endfunction

  // Directed sequence first, then randomised instructions with a
  // narrowed address range so stores and loads collide often.
  initial begin
    logic [15:0] ins;
    reset = 1'b1;
    instruction = 16'hE000;
    r1 = '0;
    r2 = '0;
    carryin = 1'b0;
    applyStimulus(16'hE000, 16'h0000, 16'h0000, 1'b0, 1'b1);
    applyStimulus(16'h8005, 16'h0000, 16'h0000, 1'b0, 1'b0);
    applyStimulus(16'h9123, 16'h0000, 16'hBEEF, 1'b0, 1'b0);
    applyStimulus(16'h8012, 16'h0000, 16'h0000, 1'b0, 1'b0);
    applyStimulus(16'h0000, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    applyStimulus(16'h1000, 16'h1234, 16'h1234, 1'b0, 1'b0);
    applyStimulus(16'hA000, 16'h1234, 16'h1234, 1'b0, 1'b0);
    applyStimulus(16'h6000, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    applyStimulus(16'h5000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    applyStimulus(16'h9123, 16'h0000, 16'h1111, 1'b0, 1'b1);
    applyStimulus(16'h8012, 16'h0000, 16'h0000, 1'b0, 1'b0);
    applyStimulus(16'hD000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    for (int n = 0; n < 3000; n++) begin
      ins = 16'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        if (ins[15:12] == 4'h8) ins[7:0] = 8'($urandom_range(0, 7));
        else ins[11:4] = 8'($urandom_range(0, 7));
      end
      applyStimulus(ins, pickOperand(), pickOperand(), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 63) == 0));
    end
    @(negedge clk);
    @(negedge clk);
    cmp("scoreboard_drain", 0, 16'(sbq.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
